// File: rtl/fetch_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_defs (package)
// Purpose  : Shared constants and FSM encoding for the wavefront fetch
//            scheduler and its round-robin arbiter.
// Contents : NUM_WF, WF_ID_WIDTH, PC_WIDTH, MAX_OUTSTANDING, CNT_WIDTH,
//            FIRST_FLAG_BIT, fetch_state_t {IDLE, REQ}
// Revision : 1.0 - initial release
// ============================================================================
package fetch_defs;

  localparam int NUM_WF          = 40;
  localparam int WF_ID_WIDTH     = 6;
  localparam int PC_WIDTH        = 32;
  localparam int MAX_OUTSTANDING = 8;
  localparam int CNT_WIDTH       = 4;

  // Bit of the PC-store read word that flags the first fetch after PC init.
  localparam int FIRST_FLAG_BIT  = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_40.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_40
// Purpose  : Combinational round-robin arbiter. Scans the request vector
//            starting one past the pointer and wrapping modulo NUM_WF.
// Ports    : req       in  NUM_WF       request vector
//            ptr       in  WF_ID_WIDTH  last granted index
//            grant     out NUM_WF       one-hot grant
//            grant_id  out WF_ID_WIDTH  encoded grant
//            any_grant out 1            at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_40
  import fetch_defs::*;
#(
  parameter int NUM_WF      = fetch_defs::NUM_WF,
  parameter int WF_ID_WIDTH = fetch_defs::WF_ID_WIDTH
) (
  input  logic [NUM_WF-1:0]      req,
  input  logic [WF_ID_WIDTH-1:0] ptr,
  output logic [NUM_WF-1:0]      grant,
  output logic [WF_ID_WIDTH-1:0] grant_id,
  output logic                   any_grant
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    // Offsets 1..NUM_WF visit every slot once, the pointer slot last.
    for (int off = 1; off <= NUM_WF; off++) begin
      idx = (int'(ptr) + off) % NUM_WF;
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = WF_ID_WIDTH'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fetch_scheduler
// Purpose  : Round-robin instruction-fetch scheduler. Tracks active and
//            fetch-pending wavefronts, reads/increments the winner's PC and
//            issues a valid/ready request to instruction memory.
// Ports    : clk, rst                      clock, sync active-high reset
//            dispatch_valid/_wf_id         wavefront launch
//            halt_valid/_wf_id             wavefront termination
//            ibuff_full                    per-wavefront buffer back-pressure
//            pc_rd_en, pc_wf_id_rd         PC store read/increment strobe
//            pc_rd_data                    {first_flag, pc} for pc_wf_id_rd
//            fetch_req_valid/ready/addr/wf_id/first   memory request
//            fetch_resp_valid/_wf_id       fetch return
//            active_mask, pending_mask     registered status vectors
// Revision : 1.0 - initial release
// ============================================================================
module fetch_scheduler
  import fetch_defs::*;
#(
  parameter int NUM_WF          = fetch_defs::NUM_WF,
  parameter int WF_ID_WIDTH     = fetch_defs::WF_ID_WIDTH,
  parameter int PC_WIDTH        = fetch_defs::PC_WIDTH,
  parameter int MAX_OUTSTANDING = fetch_defs::MAX_OUTSTANDING,
  parameter int CNT_WIDTH       = fetch_defs::CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  input  logic [WF_ID_WIDTH-1:0] dispatch_wf_id,
  input  logic                   halt_valid,
  input  logic [WF_ID_WIDTH-1:0] halt_wf_id,
  input  logic [NUM_WF-1:0]      ibuff_full,
  output logic                   pc_rd_en,
  output logic [WF_ID_WIDTH-1:0] pc_wf_id_rd,
  input  logic [PC_WIDTH:0]      pc_rd_data,
  output logic                   fetch_req_valid,
  input  logic                   fetch_req_ready,
  output logic [PC_WIDTH-1:0]    fetch_req_addr,
  output logic [WF_ID_WIDTH-1:0] fetch_req_wf_id,
  output logic                   fetch_req_first,
  input  logic                   fetch_resp_valid,
  input  logic [WF_ID_WIDTH-1:0] fetch_resp_wf_id,
  output logic [NUM_WF-1:0]      active_mask,
  output logic [NUM_WF-1:0]      pending_mask
);

  fetch_state_t           state;
  logic [NUM_WF-1:0]      active;
  logic [NUM_WF-1:0]      pending;
  logic [NUM_WF-1:0]      req_onehot;   // one-hot copy of fetch_req_wf_id
  logic [CNT_WIDTH-1:0]   count;
  logic [WF_ID_WIDTH-1:0] rr_ptr;
  logic [WF_ID_WIDTH-1:0] last_rd_id;

  logic [NUM_WF-1:0]      dispatch_hit;
  logic [NUM_WF-1:0]      halt_hit;
  logic [NUM_WF-1:0]      resp_hit;
  logic [NUM_WF-1:0]      eligible;
  logic [NUM_WF-1:0]      grant;
  logic [WF_ID_WIDTH-1:0] grant_id;
  logic                   any_grant;
  logic                   below_limit;
  logic                   accept;
  logic                   resp_ok;

  // Id decoders; ids outside 0..NUM_WF-1 match no slot and are dropped.
  always_comb begin
    dispatch_hit = '0;
    halt_hit     = '0;
    resp_hit     = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      dispatch_hit[i] = dispatch_valid   && (dispatch_wf_id   == WF_ID_WIDTH'(i));
      halt_hit[i]     = halt_valid       && (halt_wf_id       == WF_ID_WIDTH'(i));
      resp_hit[i]     = fetch_resp_valid && (fetch_resp_wf_id == WF_ID_WIDTH'(i));
    end
  end

  assign below_limit = (count < CNT_WIDTH'(MAX_OUTSTANDING));
  // A wavefront halting this cycle is masked so its PC is never bumped.
  assign eligible    = below_limit ? (active & ~pending & ~ibuff_full & ~halt_hit)
                                   : '0;
  assign accept      = (state == REQ) && fetch_req_ready;
  // Responses only count for wavefronts that really have a fetch in flight.
  assign resp_ok     = |(resp_hit & pending);

  rr_arbiter_40 #(
    .NUM_WF      (NUM_WF),
    .WF_ID_WIDTH (WF_ID_WIDTH)
  ) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  // The PC store answers combinationally, so the read strobe and id are
  // driven in the same cycle the winner is latched into the request regs.
  assign pc_rd_en        = (state == IDLE) && any_grant;
  assign pc_wf_id_rd     = pc_rd_en ? grant_id : last_rd_id;
  assign fetch_req_valid = (state == REQ);
  assign active_mask     = active;
  assign pending_mask    = pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      active          <= '0;
      pending         <= '0;
      req_onehot      <= '0;
      count           <= '0;
      rr_ptr          <= WF_ID_WIDTH'(NUM_WF - 1);
      last_rd_id      <= '0;
      fetch_req_addr  <= '0;
      fetch_req_wf_id <= '0;
      fetch_req_first <= 1'b0;
    end else begin
      // Halt is applied after dispatch so it wins on a same-id collision.
      active  <= (active | dispatch_hit) & ~halt_hit;
      pending <= (pending & ~resp_hit) | (accept ? req_onehot : '0);

      // Accept and response together cancel out.
      case ({accept, resp_ok})
        2'b10: if (count < CNT_WIDTH'(MAX_OUTSTANDING)) count <= count + CNT_WIDTH'(1);
        2'b01: if (count != '0) count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (any_grant) begin
            fetch_req_addr  <= pc_rd_data[PC_WIDTH-1:0];
            fetch_req_first <= pc_rd_data[FIRST_FLAG_BIT];
            fetch_req_wf_id <= grant_id;
            req_onehot      <= grant;
            last_rd_id      <= grant_id;
            state           <= REQ;
          end
        end
        REQ: begin
          // Request is held until accepted; a halt does not cancel it.
          if (fetch_req_ready) begin
            rr_ptr <= fetch_req_wf_id;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_scheduler
// Purpose  : Directed self-checking bench for fetch_scheduler, with a small
//            PC-store model (pc = 0x100 + id*0x1000 + 4*reads, first flag set
//            until the first read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_scheduler;

  localparam int NUM_WF = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dispatch_valid = 1'b0;
  logic [5:0]  dispatch_wf_id = '0;
  logic        halt_valid = 1'b0;
  logic [5:0]  halt_wf_id = '0;
  logic [39:0] ibuff_full = '0;
  logic        pc_rd_en;
  logic [5:0]  pc_wf_id_rd;
  logic [32:0] pc_rd_data;
  logic        fetch_req_valid;
  logic        fetch_req_ready = 1'b0;
  logic [31:0] fetch_req_addr;
  logic [5:0]  fetch_req_wf_id;
  logic        fetch_req_first;
  logic        fetch_resp_valid = 1'b0;
  logic [5:0]  fetch_resp_wf_id = '0;
  logic [39:0] active_mask;
  logic [39:0] pending_mask;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .dispatch_valid   (dispatch_valid),
    .dispatch_wf_id   (dispatch_wf_id),
    .halt_valid       (halt_valid),
    .halt_wf_id       (halt_wf_id),
    .ibuff_full       (ibuff_full),
    .pc_rd_en         (pc_rd_en),
    .pc_wf_id_rd      (pc_wf_id_rd),
    .pc_rd_data       (pc_rd_data),
    .fetch_req_valid  (fetch_req_valid),
    .fetch_req_ready  (fetch_req_ready),
    .fetch_req_addr   (fetch_req_addr),
    .fetch_req_wf_id  (fetch_req_wf_id),
    .fetch_req_first  (fetch_req_first),
    .fetch_resp_valid (fetch_resp_valid),
    .fetch_resp_wf_id (fetch_resp_wf_id),
    .active_mask      (active_mask),
    .pending_mask     (pending_mask)
  );

  always #5 clk = ~clk;

  // PC store model and edge monitors
  int fetch_cnt [64] = '{default: 0};
  int rd_pulses = 0;
  int accepts   = 0;
  logic [5:0] last_accept = '0;

  always @(posedge clk) begin
    if (pc_rd_en) begin
      fetch_cnt[pc_wf_id_rd] <= fetch_cnt[pc_wf_id_rd] + 1;
      rd_pulses <= rd_pulses + 1;
    end
    if (fetch_req_valid && fetch_req_ready) begin
      accepts     <= accepts + 1;
      last_accept <= fetch_req_wf_id;
    end
  end

  always_comb begin
    pc_rd_data = {(fetch_cnt[pc_wf_id_rd] == 0),
                  32'h100 + (32'(pc_wf_id_rd) << 12) + 32'(fetch_cnt[pc_wf_id_rd]) * 32'd4};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dispatch_valid = 1'b0; halt_valid = 1'b0; ibuff_full = '0;
    fetch_req_ready = 1'b0; fetch_resp_valid = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Launch wavefronts 0..9 with ready held high and no responses.
  task automatic fill_ten();
    fetch_req_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      dispatch_valid = (c < 10);
      dispatch_wf_id = 6'(c);
      step();
    end
    dispatch_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dispatch_valid = 1'b1; dispatch_wf_id = 6'd1;
    step(); step();
    dispatch_valid = 1'b0;
    #1;
    n_checks++;
    if ({active_mask, pending_mask} !== 80'h0) begin
      n_fail++; $display("FAIL reset_masks: got active=%h pending=%h, want 0/0", active_mask, pending_mask);
    end
    n_checks++;
    if ({pc_rd_en, pc_wf_id_rd, fetch_req_valid, fetch_req_addr, fetch_req_wf_id, fetch_req_first} !== 47'h0) begin
      n_fail++; $display("FAIL reset_outputs: got rd_en=%b id=%0d valid=%b addr=%h wf=%0d first=%b, want all 0",
                         pc_rd_en, pc_wf_id_rd, fetch_req_valid, fetch_req_addr, fetch_req_wf_id, fetch_req_first);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    do_reset();
    dispatch_valid = 1'b1; dispatch_wf_id = 6'd0;
    #1;
    n_checks++;
    if (pc_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL ff_dispatch_cycle: got rd_en=%b, want 0", pc_rd_en);
    end
    step();
    dispatch_valid = 1'b0;
    #1;
    n_checks++;
    if ({active_mask, pc_rd_en, pc_wf_id_rd} !== {40'h1, 1'b1, 6'd0}) begin
      n_fail++; $display("FAIL ff_read: got active=%h rd_en=%b id=%0d, want 1/1/0", active_mask, pc_rd_en, pc_wf_id_rd);
    end
    step();
    n_checks++;
    if ({fetch_req_valid, fetch_req_first, fetch_req_wf_id, fetch_req_addr, pc_rd_en} !== {1'b1, 1'b1, 6'd0, 32'h100, 1'b0}) begin
      n_fail++; $display("FAIL ff_request: got valid=%b first=%b wf=%0d addr=%h rd_en=%b, want 1/1/0/100/0",
                         fetch_req_valid, fetch_req_first, fetch_req_wf_id, fetch_req_addr, pc_rd_en);
    end
    fetch_req_ready = 1'b1;
    step();
    fetch_req_ready = 1'b0;
    n_checks++;
    if ({pending_mask, fetch_req_valid, pc_rd_en} !== {40'h1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL ff_accept: got pending=%h valid=%b rd_en=%b, want 1/0/0", pending_mask, fetch_req_valid, pc_rd_en);
    end
  endtask

  task automatic test_ready_stall();
    int start;
    do_reset();
    start = rd_pulses;
    dispatch_valid = 1'b1; dispatch_wf_id = 6'd10;
    step();
    dispatch_wf_id = 6'd11;
    step();
    dispatch_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if ({fetch_req_valid, fetch_req_first, fetch_req_wf_id, fetch_req_addr, pc_rd_en} !== {1'b1, 1'b1, 6'd10, 32'hA100, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b first=%b wf=%0d addr=%h rd_en=%b, want 1/1/10/a100/0",
                           k, fetch_req_valid, fetch_req_first, fetch_req_wf_id, fetch_req_addr, pc_rd_en);
      end
      step();
    end
    fetch_req_ready = 1'b1;
    step();
    fetch_req_ready = 1'b0;
    #1;
    n_checks++;
    if ({pending_mask, fetch_req_valid, pc_rd_en, pc_wf_id_rd} !== {40'h400, 1'b0, 1'b1, 6'd11}) begin
      n_fail++; $display("FAIL stall_accept: got pending=%h valid=%b rd_en=%b id=%0d, want 400/0/1/11",
                         pending_mask, fetch_req_valid, pc_rd_en, pc_wf_id_rd);
    end
    n_checks++;
    if (rd_pulses - start !== 1) begin
      n_fail++; $display("FAIL stall_single_read: got %0d read pulses, want 1", rd_pulses - start);
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int gcyc[$];
    int exp_ids[4] = '{3, 7, 39, 3};
    int dids[3]    = '{3, 7, 39};
    logic resp_next;
    logic [5:0] resp_id_next;
    do_reset();
    fetch_req_ready = 1'b1;
    resp_next = 1'b0; resp_id_next = '0;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      dispatch_valid   = (c < 3);
      dispatch_wf_id   = (c < 3) ? 6'(dids[c]) : 6'd0;
      fetch_resp_valid = resp_next;
      fetch_resp_wf_id = resp_id_next;
      #1;
      resp_next    = fetch_req_valid;
      resp_id_next = fetch_req_wf_id;
      if (pc_rd_en) begin
        grants.push_back(int'(pc_wf_id_rd));
        gcyc.push_back(c);
      end
      step();
    end
    dispatch_valid = 1'b0; fetch_resp_valid = 1'b0; fetch_req_ready = 1'b0;
    n_checks++;
    if (grants.size() !== 4) begin
      n_fail++; $display("FAIL rr_grant_count: got %0d grants within budget, want 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (grants[i] !== exp_ids[i]) begin
          n_fail++; $display("FAIL rr_order[%0d]: got wf %0d, want wf %0d", i, grants[i], exp_ids[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (gcyc[i] - gcyc[i-1] !== 2) begin
          n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles, want 2", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_halt_in_req();
    int start;
    do_reset();
    dispatch_valid = 1'b1; dispatch_wf_id = 6'd5;
    step();
    dispatch_valid = 1'b0;
    step();
    halt_valid = 1'b1; halt_wf_id = 6'd5;
    step();
    halt_valid = 1'b0;
    n_checks++;
    if ({active_mask, fetch_req_valid, fetch_req_wf_id} !== {40'h0, 1'b1, 6'd5}) begin
      n_fail++; $display("FAIL halt_req_kept: got active=%h valid=%b wf=%0d, want 0/1/5", active_mask, fetch_req_valid, fetch_req_wf_id);
    end
    fetch_req_ready = 1'b1;
    step();
    fetch_req_ready = 1'b0;
    start = rd_pulses;
    n_checks++;
    if ({pending_mask, active_mask, fetch_req_valid} !== {40'h20, 40'h0, 1'b0}) begin
      n_fail++; $display("FAIL halt_accept: got pending=%h active=%h valid=%b, want 20/0/0", pending_mask, active_mask, fetch_req_valid);
    end
    fetch_resp_valid = 1'b1; fetch_resp_wf_id = 6'd5;
    step();
    fetch_resp_valid = 1'b0;
    step(); step(); step();
    n_checks++;
    if ({pending_mask, 32'(rd_pulses - start)} !== {40'h0, 32'd0}) begin
      n_fail++; $display("FAIL halt_resp: got pending=%h extra reads=%0d, want 0/0", pending_mask, rd_pulses - start);
    end
    dispatch_valid = 1'b1; dispatch_wf_id = 6'd6; halt_valid = 1'b1; halt_wf_id = 6'd6;
    step();
    dispatch_wf_id = 6'd45; halt_valid = 1'b0;
    step();
    dispatch_wf_id = 6'd39;
    step();
    dispatch_valid = 1'b0;
    n_checks++;
    if (active_mask !== 40'h80_0000_0000) begin
      n_fail++; $display("FAIL halt_wins_and_range: got active=%h, want 8000000000", active_mask);
    end
  endtask

  task automatic test_ibuff_full();
    int start;
    do_reset();
    ibuff_full = 40'h10;
    dispatch_valid = 1'b1; dispatch_wf_id = 6'd4;
    step();
    dispatch_valid = 1'b0;
    start = rd_pulses;
    step(); step(); step();
    n_checks++;
    if ({pc_rd_en, 32'(rd_pulses - start)} !== {1'b0, 32'd0}) begin
      n_fail++; $display("FAIL ibuff_block: got rd_en=%b reads=%0d, want 0/0", pc_rd_en, rd_pulses - start);
    end
    ibuff_full = '0;
    #1;
    n_checks++;
    if ({pc_rd_en, pc_wf_id_rd} !== {1'b1, 6'd4}) begin
      n_fail++; $display("FAIL ibuff_release: got rd_en=%b id=%0d, want 1/4", pc_rd_en, pc_wf_id_rd);
    end
  endtask

  task automatic test_outstanding_limit();
    int start;
    do_reset();
    start = accepts;
    fill_ten();
    n_checks++;
    if ({32'(accepts - start), pending_mask, pc_rd_en} !== {32'd8, 40'hFF, 1'b0}) begin
      n_fail++; $display("FAIL limit_fill: got accepts=%0d pending=%h rd_en=%b, want 8/ff/0", accepts - start, pending_mask, pc_rd_en);
    end
    fetch_resp_valid = 1'b1; fetch_resp_wf_id = 6'd9;
    step();
    fetch_resp_valid = 1'b0;
    step(); step(); step();
    n_checks++;
    if ({32'(accepts - start), pc_rd_en} !== {32'd8, 1'b0}) begin
      n_fail++; $display("FAIL limit_stray_resp: got accepts=%0d rd_en=%b, want 8/0", accepts - start, pc_rd_en);
    end
    fetch_resp_valid = 1'b1; fetch_resp_wf_id = 6'd2;
    step();
    fetch_resp_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    n_checks++;
    if ({32'(accepts - start), last_accept, pending_mask, pc_rd_en} !== {32'd9, 6'd8, 40'h1FB, 1'b0}) begin
      n_fail++; $display("FAIL limit_one_more: got accepts=%0d last=%0d pending=%h rd_en=%b, want 9/8/1fb/0",
                         accepts - start, last_accept, pending_mask, pc_rd_en);
    end
    fetch_req_ready = 1'b0;
  endtask

  task automatic test_same_cycle_resp();
    int start;
    do_reset();
    start = accepts;
    fill_ten();
    fetch_resp_valid = 1'b1; fetch_resp_wf_id = 6'd0;
    step();
    fetch_resp_valid = 1'b0;
    step();
    // In REQ for wf 8 with ready high: accept and response share this edge.
    fetch_resp_valid = 1'b1; fetch_resp_wf_id = 6'd1;
    #1;
    n_checks++;
    if ({fetch_req_valid, fetch_req_wf_id} !== {1'b1, 6'd8}) begin
      n_fail++; $display("FAIL same_cycle_setup: got valid=%b wf=%0d, want 1/8", fetch_req_valid, fetch_req_wf_id);
    end
    step();
    fetch_resp_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    n_checks++;
    if ({32'(accepts - start), last_accept, pending_mask, pc_rd_en} !== {32'd10, 6'd9, 40'h3FC, 1'b0}) begin
      n_fail++; $display("FAIL same_cycle_count: got accepts=%0d last=%0d pending=%h rd_en=%b, want 10/9/3fc/0",
                         accepts - start, last_accept, pending_mask, pc_rd_en);
    end
    fetch_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    dispatch_valid = 1'b1; dispatch_wf_id = 6'd20;
    step();
    dispatch_valid = 1'b0;
    step();
    fetch_req_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    fetch_req_ready = 1'b0;
    #1;
    n_checks++;
    if ({fetch_req_valid, pending_mask, active_mask, pc_rd_en} !== {1'b0, 40'h0, 40'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid_req: got valid=%b pending=%h active=%h rd_en=%b, want all 0",
                         fetch_req_valid, pending_mask, active_mask, pc_rd_en);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_ready_stall();
    test_round_robin();
    test_halt_in_req();
    test_ibuff_full();
    test_outstanding_limit();
    test_same_cycle_resp();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
